// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline flush controller: FSM states,
// stall vector patterns (bit0 = PC ... bit6 = WB) and exception codes.
package pipe_flush_ctrl_pkg;

  localparam int STALL_W = 7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_IDLE     = 2'd3
  } state_t;

  localparam logic [STALL_W-1:0] STALL_NONE = 7'b0000000;
  localparam logic [STALL_W-1:0] STALL_PC   = 7'b0000001;
  localparam logic [STALL_W-1:0] STALL_ID   = 7'b0000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 7'b0001111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 7'b1111111;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_C1   = 2'd1,
    EXC_C2   = 2'd2,
    EXC_C3   = 2'd3
  } exc_code_t;

endpackage

// File: rtl/pipe_flush_ctrl_stall_encoder.sv
// Per-slot stall encoder: an EX or interrupt stall freezes PC..EX,
// an ID stall freezes PC..ID.
module pipe_flush_ctrl_stall_encoder
  import pipe_flush_ctrl_pkg::*;
(
  input  logic               i_id,
  input  logic               i_ex,
  input  logic               i_int,
  output logic [STALL_W-1:0] o_stall
);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    o_stall = STALL_NONE;
    if (i_ex || i_int) begin
      o_stall = STALL_EX;
    end else if (i_id) begin
      o_stall = STALL_ID;
    end
  end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Dual-issue pipeline controller: exception arbitration, timed flush, PC
// redirect handshake with IF, and idle parking until an interrupt is pending.
module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC      = 32'h0000000c,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_1,
  input  logic               stallreq_id_2,
  input  logic               stallreq_ex_1,
  input  logic               stallreq_ex_2,
  input  logic               int_stallreq,
  input  logic               idle_req,
  input  logic               int_pending,
  input  logic [1:0]         excepttype_1,
  input  logic [1:0]         excepttype_2,
  input  logic [31:0]        exc_pc_1,
  input  logic [31:0]        exc_pc_2,
  input  logic               fetch_ready,
  output logic [STALL_W-1:0] stall1,
  output logic [STALL_W-1:0] stall2,
  output logic               flush,
  output logic               new_pc_valid,
  output logic [31:0]        new_pc,
  output logic [31:0]        epc,
  output logic [1:0]         ecode,
  output logic               busy
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_latch_exc;
  logic [31:0]        w_epc_nxt;
  logic [1:0]         w_ecode_nxt;
  logic [STALL_W-1:0] w_own1, w_own2;

  pipe_flush_ctrl_stall_encoder u_enc_1 (
    .i_id    (stallreq_id_1),
    .i_ex    (stallreq_ex_1),
    .i_int   (int_stallreq),
    .o_stall (w_own1)
  );

  pipe_flush_ctrl_stall_encoder u_enc_2 (
    .i_id    (stallreq_id_2),
    .i_ex    (stallreq_ex_2),
    .i_int   (int_stallreq),
    .o_stall (w_own2)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch_exc = 1'b0;
    w_epc_nxt   = exc_pc_1;
    w_ecode_nxt = excepttype_1;
    unique case (r_state)
      ST_RUN: begin
        // Slot 1 is older in program order, so it wins a simultaneous exception.
        if (excepttype_1 != EXC_NONE) begin
          w_latch_exc = 1'b1;
        end else if (excepttype_2 != EXC_NONE) begin
          w_latch_exc = 1'b1;
          w_epc_nxt   = exc_pc_2;
          w_ecode_nxt = excepttype_2;
        end
        if (w_latch_exc) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (idle_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (fetch_ready) w_state_nxt = ST_RUN;
      end
      ST_IDLE: begin
        if (int_pending) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      flush        <= 1'b0;
      new_pc_valid <= 1'b0;
      new_pc       <= '0;
      epc          <= '0;
      ecode        <= '0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      // Outputs are decoded from the next state so they line up with the state register.
      flush        <= (w_state_nxt == ST_FLUSH);
      new_pc_valid <= (w_state_nxt == ST_REDIRECT);
      new_pc       <= (w_state_nxt == ST_REDIRECT) ? EXC_VEC : 32'h0;
      busy         <= (w_state_nxt != ST_RUN);
      if (w_latch_exc) begin
        epc   <= w_epc_nxt;
        ecode <= w_ecode_nxt;
      end
    end
  end

  always_comb begin
    stall1 = STALL_NONE;
    stall2 = STALL_NONE;
    unique case (r_state)
      ST_RUN: begin
        stall1 = w_own1;
        stall2 = w_own2 | w_own1;
      end
      ST_FLUSH, ST_REDIRECT: begin
        stall1 = STALL_PC;
        stall2 = STALL_PC;
      end
      ST_IDLE: begin
        stall1 = STALL_ALL;
        stall2 = STALL_ALL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed self-checking bench for pipe_flush_ctrl: combinational RUN stalls,
// exception arbitration, flush timing, redirect handshake, idle and reset abort.
module tb_pipe_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_1, stallreq_id_2, stallreq_ex_1, stallreq_ex_2;
  logic        int_stallreq, idle_req, int_pending, fetch_ready;
  logic [1:0]  excepttype_1, excepttype_2;
  logic [31:0] exc_pc_1, exc_pc_2;
  logic [6:0]  stall1, stall2;
  logic        flush, new_pc_valid, busy;
  logic [31:0] new_pc, epc;
  logic [1:0]  ecode;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_flush_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_1 (stallreq_id_1),
    .stallreq_id_2 (stallreq_id_2),
    .stallreq_ex_1 (stallreq_ex_1),
    .stallreq_ex_2 (stallreq_ex_2),
    .int_stallreq  (int_stallreq),
    .idle_req      (idle_req),
    .int_pending   (int_pending),
    .excepttype_1  (excepttype_1),
    .excepttype_2  (excepttype_2),
    .exc_pc_1      (exc_pc_1),
    .exc_pc_2      (exc_pc_2),
    .fetch_ready   (fetch_ready),
    .stall1        (stall1),
    .stall2        (stall2),
    .flush         (flush),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .epc           (epc),
    .ecode         (ecode),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id_1 = 0; stallreq_id_2 = 0; stallreq_ex_1 = 0; stallreq_ex_2 = 0;
    int_stallreq = 0; idle_req = 0; int_pending = 0; fetch_ready = 0;
    excepttype_1 = 0; excepttype_2 = 0; exc_pc_1 = 0; exc_pc_2 = 0;
  endtask

  task automatic check_stalls(input string tag, input logic [6:0] e1, input logic [6:0] e2);
    check({tag, "_s1"}, 32'(stall1), 32'(e1));
    check({tag, "_s2"}, 32'(stall2), 32'(e2));
  endtask

  task automatic check_redirect(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(new_pc_valid), 32'(v));
    check({tag, "_pc"}, new_pc, pc);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    check("rst_flush", 32'(flush), 0);
    check_redirect("rst", 0, 0);
    check("rst_epc", epc, 0);
    check("rst_ecode", 32'(ecode), 0);
    check("rst_busy", 32'(busy), 0);
    check_stalls("rst", 7'b0, 7'b0);
    rst = 0;
    step();

    // Combinational RUN stalls
    stallreq_ex_1 = 1; #1;
    check_stalls("ex1", 7'b0001111, 7'b0001111);
    clear_inputs(); stallreq_id_2 = 1; #1;
    check_stalls("id2", 7'b0000000, 7'b0000111);
    clear_inputs(); int_stallreq = 1; #1;
    check_stalls("int", 7'b0001111, 7'b0001111);
    clear_inputs(); stallreq_id_1 = 1; #1;
    check_stalls("id1", 7'b0000111, 7'b0000111);
    stallreq_ex_2 = 1; #1;
    check_stalls("id1_ex2", 7'b0000111, 7'b0001111);
    clear_inputs(); stallreq_id_1 = 1; stallreq_ex_1 = 1; #1;
    check_stalls("id1_ex1", 7'b0001111, 7'b0001111);
    clear_inputs();

    // Simultaneous exceptions: slot 1 wins
    excepttype_1 = 2'b01; exc_pc_1 = 32'h100;
    excepttype_2 = 2'b10; exc_pc_2 = 32'h104;
    step();
    clear_inputs();
    stallreq_ex_1 = 1; idle_req = 1; fetch_ready = 1;
    #1;
    check("f1_flush", 32'(flush), 1);
    check("f1_epc", epc, 32'h100);
    check("f1_ecode", 32'(ecode), 1);
    check("f1_busy", 32'(busy), 1);
    check_redirect("f1", 0, 0);
    check_stalls("f1", 7'b0000001, 7'b0000001);
    step();
    check("f2_flush", 32'(flush), 1);
    check_redirect("f2", 0, 0);
    clear_inputs();
    step();
    check("r0_flush", 32'(flush), 0);
    check_redirect("r0", 1, 32'h0000000c);
    check_stalls("r0", 7'b0000001, 7'b0000001);
    check("r0_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_redirect("r_hold", 1, 32'h0000000c);
    end
    fetch_ready = 1; #1;
    check_redirect("r_xfer", 1, 32'h0000000c);
    step();
    fetch_ready = 0; #1;
    check_redirect("run_after", 0, 0);
    check("run_busy", 32'(busy), 0);
    check("run_epc_hold", epc, 32'h100);
    check_stalls("run_after", 7'b0, 7'b0);

    // Slot-2-only exception, IF ready on first redirect cycle
    excepttype_2 = 2'b11; exc_pc_2 = 32'h200;
    step();
    clear_inputs();
    check("s2_epc", epc, 32'h200);
    check("s2_ecode", 32'(ecode), 3);
    check("s2_flush", 32'(flush), 1);
    fetch_ready = 1;
    step();
    step();
    check_redirect("s2_redir", 1, 32'h0000000c);
    step();
    fetch_ready = 0; #1;
    check_redirect("s2_done", 0, 0);
    check("s2_busy", 32'(busy), 0);

    // Idle until interrupt; exceptions ignored while parked
    idle_req = 1;
    step();
    idle_req = 0; #1;
    check_stalls("idle", 7'b1111111, 7'b1111111);
    check("idle_busy", 32'(busy), 1);
    excepttype_1 = 2'b01; exc_pc_1 = 32'h300;
    step();
    clear_inputs(); #1;
    check("idle_noflush", 32'(flush), 0);
    check("idle_epc", epc, 32'h200);
    check_stalls("idle_hold", 7'b1111111, 7'b1111111);
    int_pending = 1; #1;
    check_stalls("idle_wake", 7'b1111111, 7'b1111111);
    step();
    int_pending = 0; #1;
    check_stalls("woke", 7'b0, 7'b0);
    check("woke_busy", 32'(busy), 0);

    // Exception beats idle
    idle_req = 1; excepttype_2 = 2'b01; exc_pc_2 = 32'h400;
    step();
    clear_inputs(); #1;
    check("eb_flush", 32'(flush), 1);
    check("eb_epc", epc, 32'h400);
    check("eb_ecode", 32'(ecode), 1);
    check_stalls("eb", 7'b0000001, 7'b0000001);
    step();
    step();
    check_redirect("eb_redir", 1, 32'h0000000c);
    fetch_ready = 1;
    step();
    fetch_ready = 0; #1;
    check_stalls("eb_run", 7'b0, 7'b0);
    check("eb_busy", 32'(busy), 0);

    // Reset during first flush cycle abandons the sequence
    excepttype_1 = 2'b10; exc_pc_1 = 32'h500;
    step();
    clear_inputs(); #1;
    check("ra_flush1", 32'(flush), 1);
    rst = 1;
    step();
    rst = 0; #1;
    check("ra_flush", 32'(flush), 0);
    check("ra_epc", epc, 0);
    check("ra_ecode", 32'(ecode), 0);
    check("ra_busy", 32'(busy), 0);
    check_redirect("ra", 0, 0);
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_redirect("ra_none", 0, 0);
      check("ra_none_flush", 32'(flush), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
